// File: rtl/rotate_frame_ctrl_if.sv
// Stream, configuration and status bundle between the pixel source side and
// the rotator frame controller.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH        8
`define DTYPE_FRAME_START  8'h01
`define DTYPE_FRAME_END    8'h02
`define DTYPE_ROW_START    8'h04
`define DTYPE_ROW_END      8'h08
`define DTYPE_PIXEL_MASK   8'hF0
`endif

interface rotate_frame_ctrl_if #(
   parameter int ADDR_WIDTH  = 21,
   parameter int ANGLE_WIDTH = 10,
   parameter int DIM_WIDTH   = 11
);
   logic                          enable;
   logic                          dvi;
   logic [`DTYPE_WIDTH-1:0]       dtypei;
   logic [ADDR_WIDTH-1:0]         addr0;
   logic [ADDR_WIDTH-1:0]         addr1;
   logic                          cfg_update;
   logic signed [ANGLE_WIDTH-1:0] sin_req;
   logic signed [ANGLE_WIDTH-1:0] cos_req;

   logic                          rot_enable;
   logic [ADDR_WIDTH-1:0]         waddr_base;
   logic [ADDR_WIDTH-1:0]         raddr_base;
   logic signed [ANGLE_WIDTH-1:0] sin_theta;
   logic signed [ANGLE_WIDTH-1:0] cos_theta;
   logic [DIM_WIDTH-1:0]          num_cols;
   logic [DIM_WIDTH-1:0]          num_rows;
   logic                          frame_done;
   logic                          frame_err;

   modport master (
      output enable, dvi, dtypei, addr0, addr1, cfg_update, sin_req, cos_req,
      input  rot_enable, waddr_base, raddr_base, sin_theta, cos_theta,
             num_cols, num_rows, frame_done, frame_err
   );

   modport slave (
      input  enable, dvi, dtypei, addr0, addr1, cfg_update, sin_req, cos_req,
      output rot_enable, waddr_base, raddr_base, sin_theta, cos_theta,
             num_cols, num_rows, frame_done, frame_err
   );
endinterface

// File: rtl/rotate_frame_ctrl.sv
// Ping-pong buffer scheduler for the SRAM image rotator: tracks frame shape,
// picks write/read bases, and switches the rotation angle only at frame start.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | between frames (or disabled); stream events other than fs ignored
//   ST_FRAME | frame in progress; counting pixels/rows into buffer wsel
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH        8
`define DTYPE_FRAME_START  8'h01
`define DTYPE_FRAME_END    8'h02
`define DTYPE_ROW_START    8'h04
`define DTYPE_ROW_END      8'h08
`define DTYPE_PIXEL_MASK   8'hF0
`endif

module rotate_frame_ctrl #(
   parameter int ADDR_WIDTH  = 21,
   parameter int ANGLE_WIDTH = 10,
   parameter int DIM_WIDTH   = 11
) (
   input logic                clk,
   input logic                reset,
   rotate_frame_ctrl_if.slave bus
);
   typedef enum logic {ST_IDLE, ST_FRAME} state_t;

   localparam logic [DIM_WIDTH-1:0]          DIM_MAX   = '1;
   localparam logic signed [ANGLE_WIDTH-1:0] ANGLE_ONE = {2'b01, {(ANGLE_WIDTH-2){1'b0}}};
   localparam logic [DIM_WIDTH-1:0]          COLS_RST  = DIM_WIDTH'(1280);
   localparam logic [DIM_WIDTH-1:0]          ROWS_RST  = DIM_WIDTH'(720);

   state_t                        state;
   logic                          wsel;
   logic [1:0]                    valid;
   logic [DIM_WIDTH-1:0]          col_cnt;
   logic [DIM_WIDTH-1:0]          row_cnt;
   logic [DIM_WIDTH-1:0]          first_cols;
   logic                          bad;
   logic signed [ANGLE_WIDTH-1:0] sin_pend;
   logic signed [ANGLE_WIDTH-1:0] cos_pend;

   logic ev_fs, ev_fe, ev_rs, ev_re, ev_px;

   always_comb begin
      ev_fs = bus.dvi && (bus.dtypei == `DTYPE_FRAME_START);
      ev_fe = bus.dvi && (bus.dtypei == `DTYPE_FRAME_END);
      ev_rs = bus.dvi && (bus.dtypei == `DTYPE_ROW_START);
      ev_re = bus.dvi && (bus.dtypei == `DTYPE_ROW_END);
      ev_px = bus.dvi && ((bus.dtypei & `DTYPE_PIXEL_MASK) != '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_IDLE;
         wsel           <= 1'b0;
         valid          <= '0;
         col_cnt        <= '0;
         row_cnt        <= '0;
         first_cols     <= '0;
         bad            <= 1'b0;
         sin_pend       <= '0;
         cos_pend       <= ANGLE_ONE;
         bus.rot_enable <= 1'b0;
         bus.waddr_base <= '0;
         bus.raddr_base <= '0;
         bus.sin_theta  <= '0;
         bus.cos_theta  <= ANGLE_ONE;
         bus.num_cols   <= COLS_RST;
         bus.num_rows   <= ROWS_RST;
         bus.frame_done <= 1'b0;
         bus.frame_err  <= 1'b0;
      end else begin
         bus.frame_done <= 1'b0;
         bus.frame_err  <= 1'b0;

         if (bus.cfg_update) begin
            sin_pend <= bus.sin_req;
            cos_pend <= bus.cos_req;
         end

         if (!bus.enable) begin
            // Dropping valid forces the first frame after re-enable to be
            // written with the rotator held off.
            state          <= ST_IDLE;
            valid          <= '0;
            bus.rot_enable <= 1'b0;
         end else if (ev_fs) begin
            if (state == ST_FRAME) begin
               bus.frame_err <= 1'b1;
               valid[wsel]   <= 1'b0;
            end
            state          <= ST_FRAME;
            bus.waddr_base <= wsel ? bus.addr1 : bus.addr0;
            bus.raddr_base <= wsel ? bus.addr0 : bus.addr1;
            bus.rot_enable <= valid[~wsel];
            bus.sin_theta  <= bus.cfg_update ? bus.sin_req : sin_pend;
            bus.cos_theta  <= bus.cfg_update ? bus.cos_req : cos_pend;
            col_cnt        <= '0;
            row_cnt        <= '0;
            first_cols     <= '0;
            bad            <= 1'b0;
         end else if (state == ST_FRAME) begin
            if (ev_fe) begin
               if (!bad && (row_cnt != '0) && (first_cols != '0)) begin
                  valid[wsel]    <= 1'b1;
                  bus.num_cols   <= first_cols;
                  bus.num_rows   <= row_cnt;
                  wsel           <= ~wsel;
                  bus.frame_done <= 1'b1;
               end else begin
                  valid[wsel]   <= 1'b0;
                  bus.frame_err <= 1'b1;
               end
               state <= ST_IDLE;
            end else if (ev_rs) begin
               col_cnt <= '0;
            end else if (ev_re) begin
               if (row_cnt == DIM_MAX)
                  bad <= 1'b1;
               else
                  row_cnt <= row_cnt + 1'b1;
               // The first completed row defines the frame width.
               if (row_cnt == '0)
                  first_cols <= col_cnt;
               else if (col_cnt != first_cols)
                  bad <= 1'b1;
            end else if (ev_px) begin
               if (col_cnt == DIM_MAX)
                  bad <= 1'b1;
               else
                  col_cnt <= col_cnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_rotate_frame_ctrl.sv
// Directed bench for rotate_frame_ctrl: buffer ping-pong, malformed frames,
// angle switching, enable gating and mid-frame reset.
module tb_rotate_frame_ctrl;
   localparam logic [7:0] DT_FS = 8'h01;
   localparam logic [7:0] DT_FE = 8'h02;
   localparam logic [7:0] DT_RS = 8'h04;
   localparam logic [7:0] DT_RE = 8'h08;
   localparam logic [7:0] DT_PX = 8'h10;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   done_cnt = 0;
   int   err_cnt = 0;

   rotate_frame_ctrl_if bus ();
   rotate_frame_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.frame_done === 1'b1) done_cnt++;
      if (bus.frame_err === 1'b1) err_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ev(input logic [7:0] dt);
      bus.dvi = 1'b1;
      bus.dtypei = dt;
      tick();
      bus.dvi = 1'b0;
      bus.dtypei = 8'h00;
   endtask

   task automatic rows(input int n_rows, input int n_cols);
      for (int r = 0; r < n_rows; r++) begin
         ev(DT_RS);
         for (int c = 0; c < n_cols; c++) ev(DT_PX);
         ev(DT_RE);
      end
   endtask

   task automatic cfg(input int s, input int c);
      bus.cfg_update = 1'b1;
      bus.sin_req = 10'(s);
      bus.cos_req = 10'(c);
      tick();
      bus.cfg_update = 1'b0;
   endtask

   task automatic check_fs(input string tag, input int wa, input int ra, input int ren);
      check({tag, "_waddr"}, 32'(bus.waddr_base), wa);
      check({tag, "_raddr"}, 32'(bus.raddr_base), ra);
      check({tag, "_rot_en"}, 32'(bus.rot_enable), ren);
   endtask

   task automatic check_reset(input string tag);
      check_fs(tag, 0, 0, 0);
      check({tag, "_sin"}, int'(bus.sin_theta), 0);
      check({tag, "_cos"}, int'(bus.cos_theta), 256);
      check({tag, "_cols"}, 32'(bus.num_cols), 1280);
      check({tag, "_rows"}, 32'(bus.num_rows), 720);
      check({tag, "_done"}, 32'(bus.frame_done), 0);
      check({tag, "_err"}, 32'(bus.frame_err), 0);
   endtask

   initial begin
      reset = 1'b1;
      bus.enable = 1'b1;
      bus.dvi = 1'b0;
      bus.dtypei = 8'h00;
      bus.addr0 = 21'h100;
      bus.addr1 = 21'h200;
      bus.cfg_update = 1'b0;
      bus.sin_req = '0;
      bus.cos_req = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check_reset("rst");

      // Frame 1: first write goes to addr0, rotator off
      ev(DT_FS);
      check_fs("f1", 'h100, 'h200, 0);
      rows(3, 4);
      ev(DT_FE);
      check("f1_done", 32'(bus.frame_done), 1);
      check("f1_err", 32'(bus.frame_err), 0);
      check("f1_cols", 32'(bus.num_cols), 4);
      check("f1_rows", 32'(bus.num_rows), 3);
      tick();
      check("f1_done_pulse", 32'(bus.frame_done), 0);

      // Frame 2: ping-pong to addr1, read the frame just stored
      ev(DT_FS);
      check_fs("f2", 'h200, 'h100, 1);
      rows(3, 4);
      ev(DT_FE);
      check("f2_done", 32'(bus.frame_done), 1);

      // Frame 3: row 2 is 5 wide -> discarded
      ev(DT_FS);
      check_fs("f3", 'h100, 'h200, 1);
      rows(1, 4);
      rows(1, 5);
      rows(1, 4);
      ev(DT_FE);
      check("f3_err", 32'(bus.frame_err), 1);
      check("f3_done", 32'(bus.frame_done), 0);
      check("f3_cols", 32'(bus.num_cols), 4);
      check("f3_rows", 32'(bus.num_rows), 3);

      // Frame 4: same write base again; interrupted by a second fs
      ev(DT_FS);
      check_fs("f4", 'h100, 'h200, 1);
      rows(2, 4);
      ev(DT_FS);
      check("f4_restart_err", 32'(bus.frame_err), 1);
      check_fs("f4b", 'h100, 'h200, 1);
      tick();
      check("f4_err_pulse", 32'(bus.frame_err), 0);
      rows(2, 5);
      ev(DT_FE);
      check("f4b_done", 32'(bus.frame_done), 1);
      check("f4b_cols", 32'(bus.num_cols), 5);
      check("f4b_rows", 32'(bus.num_rows), 2);

      // Frame 5: angle request mid-frame waits for the next fs
      ev(DT_FS);
      check_fs("f5", 'h200, 'h100, 1);
      cfg(181, 181);
      check("f5_sin_hold", int'(bus.sin_theta), 0);
      check("f5_cos_hold", int'(bus.cos_theta), 256);
      rows(1, 3);
      ev(DT_FE);
      check("f5_sin_after_fe", int'(bus.sin_theta), 0);
      check("f5_cols", 32'(bus.num_cols), 3);
      check("f5_rows", 32'(bus.num_rows), 1);

      ev(DT_FS);
      check("f6_sin", int'(bus.sin_theta), 181);
      check("f6_cos", int'(bus.cos_theta), 181);
      check("f6_waddr", 32'(bus.waddr_base), 'h100);
      rows(1, 3);
      ev(DT_FE);

      // Frame 7: request coincident with fs takes effect immediately
      bus.cfg_update = 1'b1;
      bus.sin_req = 10'sd0;
      bus.cos_req = -10'sd256;
      ev(DT_FS);
      bus.cfg_update = 1'b0;
      check("f7_sin", int'(bus.sin_theta), 0);
      check("f7_cos", int'(bus.cos_theta), -256);
      check("f7_waddr", 32'(bus.waddr_base), 'h200);
      rows(1, 3);
      ev(DT_FE);

      // Frame 8: enable dropped mid-frame; fe while disabled is ignored
      ev(DT_FS);
      check_fs("f8", 'h100, 'h200, 1);
      rows(1, 3);
      bus.enable = 1'b0;
      tick();
      check("f8_dis_rot_en", 32'(bus.rot_enable), 0);
      ev(DT_FE);
      check("f8_dis_done", 32'(bus.frame_done), 0);
      check("f8_dis_err", 32'(bus.frame_err), 0);
      bus.enable = 1'b1;
      tick();

      // Frame 9: held wsel, rotator still off; frame 10 re-enables it
      ev(DT_FS);
      check_fs("f9", 'h100, 'h200, 0);
      rows(2, 2);
      ev(DT_FE);
      check("f9_done", 32'(bus.frame_done), 1);
      check("f9_cols", 32'(bus.num_cols), 2);
      ev(DT_FS);
      check_fs("f10", 'h200, 'h100, 1);
      rows(2, 2);
      ev(DT_FE);

      // Frame 11: reset mid-frame, the remainder must not complete a frame
      ev(DT_FS);
      ev(DT_RS);
      ev(DT_PX);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_reset("midrst");
      ev(DT_PX);
      ev(DT_RE);
      rows(1, 2);
      ev(DT_FE);
      check("f11_done", 32'(bus.frame_done), 0);
      check("f11_err", 32'(bus.frame_err), 0);

      ev(DT_FS);
      check_fs("f12", 'h100, 'h200, 0);
      rows(2, 2);
      ev(DT_FE);
      check("f12_done", 32'(bus.frame_done), 1);
      tick();

      check("total_done", done_cnt, 9);
      check("total_err", err_cnt, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rotate_frame_ctrl.md
# rotate_frame_ctrl

Frame-level controller for the SRAM-backed image rotator. It watches the same pixel stream the rotator sees and owns the ping-pong buffer scheduling: which SRAM base the incoming frame is written to, and which base holds the last complete frame to read from. It also measures frame dimensions and applies angle updates only at frame boundaries. It gates the rotator's enable, so the rotator runs only when a complete, well-formed frame is in the read buffer.

## Interface
- ADDR_WIDTH, 21, SRAM word address width
- ANGLE_WIDTH, 10, signed sin/cos width; 1.0 = 2^(ANGLE_WIDTH-2)
- DIM_WIDTH, 11, row/col counter width
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-high
- enable  in  1  block enable; low = bypass rotation
- dvi  in  1  stream data valid
- dtypei  in  `DTYPE_WIDTH  stream type (FRAME_START/END, ROW_START/END, pixel per `DTYPE_PIXEL_MASK)
- addr0, addr1  in  ADDR_WIDTH each  buffer base addresses (equal = single buffer)
- cfg_update  in  1  one-cycle strobe: capture sin_req/cos_req
- sin_req, cos_req  in  ANGLE_WIDTH signed  requested rotation
- rot_enable  out  1  enable to rotator
- waddr_base  out  ADDR_WIDTH  base address for the current frame's writes
- raddr_base  out  ADDR_WIDTH  base address for the current frame's reads
- sin_theta, cos_theta  out  ANGLE_WIDTH signed  active rotation, frame-stable
- num_cols, num_rows  out  DIM_WIDTH  dimensions of the last good frame
- frame_done  out  1  pulse: frame stored well-formed
- frame_err  out  1  pulse: frame discarded

## Operation
- Decoded events (dvi-qualified): fs, fe, rs, re, px.
- State: wsel (buffer being written), valid[1:0] (buffer holds a good frame), FSM IDLE/FRAME.
- IDLE, fs -> FRAME. On entry, in the same edge:
  - waddr_base <= wsel ? addr1 : addr0
  - raddr_base <= wsel ? addr0 : addr1
  - rot_enable <= enable & valid[~wsel]
  - pending angle copied to sin/cos_theta
  - col_cnt, row_cnt, first_cols, bad cleared
- FRAME counting:
  - px: col_cnt++
  - rs: col_cnt <= 0
  - re: row_cnt++. First row latches first_cols <= col_cnt. Later rows with col_cnt != first_cols set bad.
  - Either counter at 2^DIM_WIDTH-1 saturates and sets bad.
- FRAME, fe:
  - Good frame (!bad, row_cnt > 0, first_cols > 0): valid[wsel] <= 1, num_cols <= first_cols, num_rows <= row_cnt, wsel toggles, frame_done pulses.
  - Otherwise: valid[wsel] <= 0, wsel unchanged, frame_err pulses.
  - Either case -> IDLE.
- FRAME, fs (missing fe): frame_err pulses, valid[wsel] <= 0, wsel unchanged. FSM stays in FRAME and performs the full entry actions for the new frame.
- fe, rs, re or px seen in IDLE: ignored; no pulse.
- Angle handling:
  - cfg_update latches sin_req/cos_req into the pending registers at any time; latest strobe wins.
  - Active angle changes only on fs. If cfg_update and fs occur in the same cycle, the new request becomes active directly.
- enable low:
  - FSM -> IDLE, valid <= 0, rot_enable <= 0.
  - wsel, num_cols and num_rows are held.
  - cfg_update still accepted.
  - The first frame after enable rises is always written with rot_enable = 0.
- addr0 == addr1: scheduling is unchanged. Read/write share the base by design.

## Timing
- All outputs registered; each update appears one cycle after the qualifying input edge.
- fs in cycle N -> waddr_base, raddr_base, rot_enable and sin/cos_theta valid from N+1 until the next fs.
- fe in cycle N -> frame_done/frame_err high in cycle N+1 only.
- Reset values:
  - rot_enable 0, waddr_base 0, raddr_base 0
  - sin_theta 0, cos_theta 2^(ANGLE_WIDTH-2) (256 at default)
  - pending angle equals the active reset values
  - num_cols 1280, num_rows 720
  - frame_done 0, frame_err 0
  - wsel 0, valid 0, IDLE
- Reset asserted mid-frame returns to reset values on the next edge; the partial frame is never marked valid.

## Test plan
- Reset, then two good 4x3 frames (addr0=0x100, addr1=0x200):
  - Frame 1: waddr_base=0x100, rot_enable=0, frame_done once, num_cols=4, num_rows=3.
  - Frame 2: waddr_base=0x200, raddr_base=0x100, rot_enable=1.
- Row 2 carries 5 pixels in a 4-wide frame -> frame_err pulse, num_cols/num_rows unchanged, next frame rewrites the same waddr_base, rot_enable follows the other buffer's valid bit.
- fs mid-frame with no fe -> one frame_err pulse in the next cycle, FSM remains FRAME, the new frame completes with frame_done.
- cfg_update sin=181, cos=181 mid-frame -> outputs stay 0/256 until the next fs, then 181/181 at fs+1. cfg_update coincident with fs -> new value active at fs+1.
- enable dropped mid-frame 2, raised before frame 3 -> rot_enable=0 through frame 3, frame 3 writes the buffer selected by the held wsel, rot_enable=1 at frame 4.
- Reset asserted mid-frame of a 2x2 stream -> all outputs at reset values next cycle, no frame_done for that frame.
